// File: rtl/polling_port_scanner.sv
// Polls the downstream port picked by the one-hot polling strobe, captures its
// status word (or records a timeout) and raises sticky per-port change flags.
module polling_port_scanner #(
  parameter int NUMBER_OF_PORTS = 4,
  parameter int STATUS_WIDTH    = 8,
  parameter int TIMEOUT_CYCLES  = 16
) (
  input  logic                                    clock,
  input  logic                                    reset_n,
  input  logic [NUMBER_OF_PORTS-1:0]              polling_clock,
  output logic [NUMBER_OF_PORTS-1:0]              port_req,
  input  logic [NUMBER_OF_PORTS-1:0]              port_ack,
  input  logic [NUMBER_OF_PORTS*STATUS_WIDTH-1:0] port_status,
  input  logic [NUMBER_OF_PORTS-1:0]              change_clear,
  output logic [NUMBER_OF_PORTS*STATUS_WIDTH-1:0] status_table,
  output logic [NUMBER_OF_PORTS-1:0]              change_bitmap,
  output logic                                    change_pending,
  output logic [NUMBER_OF_PORTS-1:0]              timeout_bitmap,
  output logic                                    overrun,
  output logic                                    busy
);
  localparam int NP = NUMBER_OF_PORTS;
  localparam int SW = STATUS_WIDTH;
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic {IDLE, REQ} state_e;

  state_e                  state_q;
  logic [NP-1:0]           strobe_q, req_q, change_q, change_d, timeout_q, chg_set;
  logic [NP-1:0][SW-1:0]   table_q, stat_w;
  logic [TW-1:0]           timer_q;
  logic                    overrun_q, busy_q;
  logic                    is_onehot, poll_start, ack_hit, timer_last;
  logic [SW-1:0]           sel_new, sel_old;

  assign stat_w = port_status;

  always_comb begin
    sel_new = '0;
    sel_old = '0;
    for (int i = 0; i < NP; i++) begin
      if (req_q[i]) begin
        sel_new = stat_w[i];
        sel_old = table_q[i];
      end
    end
    is_onehot  = (polling_clock != '0) && ((polling_clock & (polling_clock - NP'(1))) == '0);
    poll_start = (polling_clock != strobe_q) && is_onehot;
    // req_q is zero outside REQ, so this also masks acks while idle
    ack_hit    = |(port_ack & req_q);
    timer_last = (timer_q == TW'(TIMEOUT_CYCLES - 1));
    chg_set    = (state_q == REQ && ack_hit && sel_new != sel_old) ? req_q : '0;
    // a set in the same cycle as a clear must survive
    change_d   = (change_q & ~change_clear) | chg_set;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      strobe_q  <= '0;
      req_q     <= '0;
      timer_q   <= '0;
      table_q   <= '0;
      change_q  <= '0;
      timeout_q <= '0;
      overrun_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      strobe_q <= polling_clock;
      change_q <= change_d;
      case (state_q)
        IDLE: begin
          if (poll_start) begin
            state_q <= REQ;
            req_q   <= polling_clock;
            timer_q <= '0;
            busy_q  <= 1'b1;
          end
        end
        REQ: begin
          if (poll_start) overrun_q <= 1'b1;
          if (ack_hit) begin
            for (int i = 0; i < NP; i++)
              if (req_q[i]) table_q[i] <= sel_new;
            timeout_q <= timeout_q & ~req_q;
            req_q     <= '0;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end else if (timer_last) begin
            timeout_q <= timeout_q | req_q;
            req_q     <= '0;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign port_req       = req_q;
  assign status_table   = table_q;
  assign change_bitmap  = change_q;
  assign change_pending = |change_q;
  assign timeout_bitmap = timeout_q;
  assign overrun        = overrun_q;
  assign busy           = busy_q;
endmodule
